// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared state encoding and reset configuration for counter_seq_ctrl
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // Power-up config is a free-running full-range up counter; the limit resets to all ones.
   localparam logic RST_RELOAD = 1'b1;
   localparam logic RST_DOWN   = 1'b0;

   function automatic logic is_busy(input state_t s);
      return (s == ST_RUN) || (s == ST_HOLD);
   endfunction

endpackage

// File: rtl/counter_seq_ctrl_tick_prescaler.sv
// rtl/counter_seq_ctrl_tick_prescaler.sv - wrapping 0..PRESCALE-1 divider producing the count step strobe
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   // With PRESCALE=1 the counter never leaves zero, so step is permanently high.
   assign step = (r_cnt == LAST);

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - configures, sequences and supervises a prescaled up/down counter
module counter_seq_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic             cfg_reload,
   input  logic             cfg_down,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             done_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             done,
   output logic             busy,
   output logic [1:0]       state
);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_limit;
   logic             r_reload;
   logic             r_down;
   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic             r_done;

   logic             w_cfg_acc;
   logic             w_busy;
   logic             w_active;
   logic             w_tick;
   logic             w_step;
   logic             w_term;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] w_e;
   logic [WIDTH-1:0] w_limit_n;
   logic             w_down_n;
   logic [WIDTH-1:0] w_s_n;

   assign w_busy    = is_busy(r_state);
   assign w_cfg_acc = cfg_valid & ~w_busy;

   // Counting continues in HOLD as soon as pause drops, so a pause of N cycles costs exactly N.
   assign w_active  = w_busy & ~pause;
   assign w_step    = w_active & w_tick & ~abort;

   assign w_s       = r_down ? r_limit : '0;
   assign w_e       = r_down ? '0 : r_limit;
   assign w_term    = w_step & (r_q == w_e);

   // Start value as seen by a start coinciding with a config handshake.
   assign w_limit_n = w_cfg_acc ? cfg_limit : r_limit;
   assign w_down_n  = w_cfg_acc ? cfg_down : r_down;
   assign w_s_n     = w_down_n ? w_limit_n : '0;

   tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk (clk),
      .rst (rst),
      .en  (w_active & ~abort),
      .clr (abort | ~w_busy),
      .step(w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  w_next = ST_RUN;
               end else if (w_cfg_acc) begin
                  w_next = ST_IDLE;
               end
            end
            ST_RUN, ST_HOLD: begin
               if (w_term && !r_reload) begin
                  w_next = ST_DONE;
               end else if (pause) begin
                  w_next = ST_HOLD;
               end else begin
                  w_next = ST_RUN;
               end
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = w_busy;
      cfg_ready = ~w_busy;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_limit  <= '1;
         r_reload <= RST_RELOAD;
         r_down   <= RST_DOWN;
      end else if (w_cfg_acc) begin
         r_limit  <= cfg_limit;
         r_reload <= cfg_reload;
         r_down   <= cfg_down;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q    <= '0;
         r_tc   <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (abort) begin
            r_q <= w_s_n;
         end else if (!w_busy) begin
            if (start || w_cfg_acc) begin
               r_q <= w_s_n;
            end
            if (start || done_clr) begin
               r_done <= 1'b0;
            end
         end else begin
            if (w_step) begin
               if (w_term) begin
                  r_tc <= 1'b1;
                  if (r_reload) begin
                     r_q <= w_s;
                  end
               end else begin
                  r_q <= r_down ? r_q - 1'b1 : r_q + 1'b1;
               end
            end
            // A one-shot completion wins over a simultaneous clear.
            if (w_term && !r_reload) begin
               r_done <= 1'b1;
            end else if (done_clr) begin
               r_done <= 1'b0;
            end
         end
      end
   end

   assign q     = r_q;
   assign tc    = r_tc;
   assign done  = r_done;
   assign state = r_state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - randomized self-checking bench for counter_seq_ctrl at PRESCALE 1 and 3
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [3:0] cfg_limit = 4'd0;
   logic       cfg_reload = 1'b0;
   logic       cfg_down = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       abort = 1'b0;
   logic       done_clr = 1'b0;

   logic [3:0] q1, q3;
   logic       tc1, tc3, done1, done3, busy1, busy3, rdy1, rdy3;
   logic [1:0] st1, st3;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   counter_seq_ctrl #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
      .cfg_limit(cfg_limit), .cfg_reload(cfg_reload), .cfg_down(cfg_down),
      .start(start), .pause(pause), .abort(abort), .done_clr(done_clr),
      .q(q1), .tc(tc1), .done(done1), .busy(busy1), .state(st1)
   );

   counter_seq_ctrl #(.WIDTH(4), .PRESCALE(3)) u_dut3 (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy3),
      .cfg_limit(cfg_limit), .cfg_reload(cfg_reload), .cfg_down(cfg_down),
      .start(start), .pause(pause), .abort(abort), .done_clr(done_clr),
      .q(q3), .tc(tc3), .done(done3), .busy(busy3), .state(st3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: after a start edge, k counts cycles with pause low; steps = k / P.
   task automatic run_and_compare(input int L, input int d, input int r, input int n, input int pmode);
      int k, left, P, steps, pos, eq, etc, est, edone, ebusy;
      bit lp, la;
      logic [3:0] aq;
      logic [1:0] ast;
      logic atc, adone, abusy, ardy;
      k = 0; left = 4; lp = 0; la = 0;
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < 2; i++) begin
            P = (i == 0) ? 1 : 3;
            steps = k / P;
            if (r == 0 && steps >= L + 1) begin
               eq = d ? 0 : L; est = 3; edone = 1;
               etc = (la && (k % P == 0) && steps == L + 1) ? 1 : 0;
            end else begin
               pos = steps % (L + 1);
               eq = d ? L - pos : pos; est = lp ? 2 : 1; edone = 0;
               etc = (la && k > 0 && (k % P == 0) && (steps % (L + 1) == 0)) ? 1 : 0;
            end
            ebusy = (est == 1 || est == 2) ? 1 : 0;
            aq = (i == 0) ? q1 : q3;
            atc = (i == 0) ? tc1 : tc3;
            ast = (i == 0) ? st1 : st3;
            adone = (i == 0) ? done1 : done3;
            abusy = (i == 0) ? busy1 : busy3;
            ardy = (i == 0) ? rdy1 : rdy3;
            total++;
            if (aq !== 4'(eq)) begin
               bad++;
               $display("FAIL run_q P=%0d L=%0d d=%0d r=%0d k=%0d: got %0d want %0d", P, L, d, r, k, aq, eq);
            end
            total++;
            if (atc !== 1'(etc)) begin
               bad++;
               $display("FAIL run_tc P=%0d L=%0d k=%0d: got %0b want %0d", P, L, k, atc, etc);
            end
            total++;
            if (ast !== 2'(est)) begin
               bad++;
               $display("FAIL run_state P=%0d L=%0d k=%0d: got %0d want %0d", P, L, k, ast, est);
            end
            total++;
            if (adone !== 1'(edone)) begin
               bad++;
               $display("FAIL run_done P=%0d L=%0d k=%0d: got %0b want %0d", P, L, k, adone, edone);
            end
            total++;
            if (abusy !== 1'(ebusy) || ardy !== 1'(1 - ebusy)) begin
               bad++;
               $display("FAIL run_busy P=%0d k=%0d: got busy=%0b ready=%0b want busy=%0d", P, k, abusy, ardy, ebusy);
            end
         end
         if (pmode == 1) pause = ($urandom_range(0, 3) == 0);
         else if (pmode == 2 && k == 4 && left > 0) begin pause = 1'b1; left--; end
         else pause = 1'b0;
         lp = pause; la = !pause;
         tick();
         if (!lp) k++;
      end
      pause = 1'b0;
   endtask

   task automatic go_idle();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic do_start(input int with_cfg, input int L, input int d, input int r);
      if (with_cfg != 0) begin
         cfg_valid = 1'b1; cfg_limit = 4'(L); cfg_down = 1'(d); cfg_reload = 1'(r);
      end
      start = 1'b1;
      tick();
      start = 1'b0; cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      total++;
      if (q1 !== 4'd0 || q3 !== 4'd0 || st1 !== 2'd0 || st3 !== 2'd0 || done1 !== 1'b0 || tc1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got q=%0d/%0d st=%0d/%0d done=%0b tc=%0b want zeros", q1, q3, st1, st3, done1, tc1);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
      total++;
      if (rdy1 !== 1'b1 || rdy3 !== 1'b1 || busy1 !== 1'b0 || st1 !== 2'd0 || q1 !== 4'd0) begin
         bad++;
         $display("FAIL reset_idle: got ready=%0b/%0b busy=%0b st=%0d q=%0d want ready=1 busy=0 st=0 q=0", rdy1, rdy3, busy1, st1, q1);
      end
   endtask

   task automatic test_free_run();
      do_start(0, 0, 0, 0);
      run_and_compare(15, 0, 1, 40, 0);
      go_idle();
   endtask

   task automatic test_oneshot();
      cfg_valid = 1'b1; cfg_limit = 4'd5; cfg_down = 1'b0; cfg_reload = 1'b0;
      tick();
      cfg_valid = 1'b0;
      do_start(0, 0, 0, 0);
      run_and_compare(5, 0, 0, 25, 0);
      total++;
      if (rdy1 !== 1'b1 || rdy3 !== 1'b1 || done1 !== 1'b1 || done3 !== 1'b1) begin
         bad++;
         $display("FAIL oneshot_ready: got ready=%0b/%0b done=%0b/%0b want all 1", rdy1, rdy3, done1, done3);
      end
      done_clr = 1'b1;
      tick();
      done_clr = 1'b0;
      total++;
      if (done1 !== 1'b0 || done3 !== 1'b0 || st1 !== 2'd3 || q1 !== 4'd5) begin
         bad++;
         $display("FAIL done_clr: got done=%0b/%0b st=%0d q=%0d want done=0 st=3 q=5", done1, done3, st1, q1);
      end
   endtask

   task automatic test_down_reload();
      do_start(1, 2, 1, 1);
      run_and_compare(2, 1, 1, 30, 0);
      go_idle();
   endtask

   task automatic test_pause();
      do_start(1, 9, 0, 0);
      run_and_compare(9, 0, 0, 45, 2);
      do_start(1, 9, 0, 1);
      run_and_compare(9, 0, 1, 50, 1);
      go_idle();
   endtask

   task automatic test_abort_handshake();
      do_start(1, 7, 0, 1);
      run_and_compare(7, 0, 1, 3, 0);
      cfg_valid = 1'b1; cfg_limit = 4'd4; cfg_down = 1'b1; cfg_reload = 1'b1;
      total++;
      if (rdy1 !== 1'b0 || rdy3 !== 1'b0) begin
         bad++;
         $display("FAIL stall_ready: got %0b/%0b want 0", rdy1, rdy3);
      end
      tick();
      total++;
      if (st1 !== 2'd1 || q1 !== 4'd4 || rdy1 !== 1'b0) begin
         bad++;
         $display("FAIL stall_run: got st=%0d q=%0d ready=%0b want st=1 q=4 ready=0", st1, q1, rdy1);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (st1 !== 2'd0 || st3 !== 2'd0 || q1 !== 4'd0 || q3 !== 4'd0 || tc1 !== 1'b0 || tc3 !== 1'b0) begin
         bad++;
         $display("FAIL abort: got st=%0d/%0d q=%0d/%0d tc=%0b/%0b want idle q=0 tc=0", st1, st3, q1, q3, tc1, tc3);
      end
      tick();
      cfg_valid = 1'b0;
      total++;
      if (q1 !== 4'd4 || q3 !== 4'd4 || st1 !== 2'd0) begin
         bad++;
         $display("FAIL late_accept: got q=%0d/%0d st=%0d want q=4 st=0", q1, q3, st1);
      end
      do_start(0, 0, 0, 0);
      run_and_compare(4, 1, 1, 20, 0);
      go_idle();
   endtask

   task automatic test_edge_cases();
      do_start(1, 0, 0, 0);
      run_and_compare(0, 0, 0, 8, 0);
      do_start(1, 12, 0, 1);
      run_and_compare(12, 0, 1, 5, 0);
      #3 rst = 1'b1;
      #1;
      total++;
      if (q1 !== 4'd0 || q3 !== 4'd0 || st1 !== 2'd0 || st3 !== 2'd0 || tc1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
         bad++;
         $display("FAIL async_rst: got q=%0d/%0d st=%0d/%0d tc=%0b done=%0b busy=%0b want reset values", q1, q3, st1, st3, tc1, done1, busy1);
      end
      #1 rst = 1'b0;
      tick();
      do_start(0, 0, 0, 0);
      run_and_compare(15, 0, 1, 40, 1);
      go_idle();
   endtask

   task automatic test_random();
      int L, d, r;
      for (int it = 0; it < 8; it++) begin
         L = $urandom_range(0, 15);
         d = $urandom_range(0, 1);
         r = $urandom_range(0, 1);
         do_start(1, L, d, r);
         run_and_compare(L, d, r, (L + 1) * 3 + 12, 1);
         go_idle();
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_oneshot();
      test_down_reload();
      test_pause();
      test_abort_handshake();
      test_edge_cases();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Controller that configures, sequences and supervises a WIDTH-bit counter datapath.
- Accepts a configuration over a valid/ready handshake: terminal limit, direction, one-shot or auto-reload.
- Then runs, pauses, aborts and reports terminal-count events.
- Sits between a software/config master and the counter; drives the count value q and the status flags.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESCALE, 1, clock cycles per count step (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config can be accepted.
- cfg_limit  input  WIDTH  terminal value L.
- cfg_reload  input  1  1=auto-reload, 0=one-shot.
- cfg_down  input  1  1=count down (L..0), 0=count up (0..L).
- start  input  1  start counting (pulse or level).
- pause  input  1  level; freezes the count while high.
- abort  input  1  return to idle immediately.
- done_clr  input  1  clears sticky done.
- q  output  WIDTH  current count.
- tc  output  1  one-cycle terminal-count pulse.
- done  output  1  sticky one-shot completion flag.
- busy  output  1  state is RUN or HOLD.
- state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11.

Behaviour:
- Reset (async, any time, including mid-count):
  - state=IDLE, q=0, tc=0, done=0, prescaler=0.
  - Latched config: limit=all ones, reload=1, down=0.
- Start value S = L when down=1, else 0. End value E = 0 when down=1, else L.
- cfg_ready=1 in IDLE and DONE, 0 in RUN and HOLD. A busy controller stalls the master.
- Config accept (cfg_valid & cfg_ready):
  - Latch limit/reload/down.
  - q <= new S next cycle.
  - State becomes IDLE (DONE also goes to IDLE); done unchanged.
- start in IDLE/DONE -> RUN next cycle; q <= S; prescaler cleared; done cleared.
  - If config is accepted in the same cycle, start uses the new config.
- start in RUN/HOLD is ignored.
- RUN:
  - Prescaler counts 0..PRESCALE-1; a step occurs on the cycle it reaches PRESCALE-1, then it wraps to 0.
  - Step with q!=E: q increments (up) or decrements (down).
  - Step with q==E: tc=1 for exactly one cycle (registered, coincident with the q update). Then:
    - reload=1: q <= S, stay in RUN.
    - reload=0: q holds E, go to DONE, done<=1.
  - Period = (L+1)*PRESCALE cycles.
  - L=0: every step is terminal (tc every PRESCALE cycles, or immediate DONE).
- Wrap-around: q never passes E. For L = all ones, up-count 0..2^WIDTH-1 reloads to 0 with no overflow glitch.
- HOLD:
  - pause=1 in RUN -> HOLD next cycle. A step due in that same cycle is suppressed; prescaler and q are frozen.
  - pause=0 -> RUN; counting resumes from the frozen prescaler value.
  - pause in IDLE/DONE has no effect.
- abort (priority below reset, above everything else):
  - From any state -> IDLE next cycle; q <= S; prescaler=0; tc=0.
  - done unchanged; a simultaneous terminal step is discarded.
- done:
  - Set by one-shot completion, cleared by done_clr or start.
  - Set wins over a simultaneous done_clr.
- busy and cfg_ready are combinational decodes of state. All other outputs are registered.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state enum: IDLE, RUN, HOLD, DONE.
  - Reset constants for the latched config.
- One sub-module: tick_prescaler.
  - Parameter PRESCALE; inputs clk, rst, en, clr; output step.
  - Wrapping 0..PRESCALE-1 counter; step is constant 1 when PRESCALE=1.

Test Plan:
- Reset then idle (PRESCALE=1): pulse rst with no config -> q=0, state=00, cfg_ready=1, done=0.
  - start -> q counts 0..15, tc at 15->0, period 16 cycles.
- Up, one-shot: cfg L=5, reload=0, down=0; start.
  - Required: q=0,1,2,3,4,5 on consecutive cycles.
  - Next step: tc=1 for one cycle, q stays 5, state=11, done=1.
  - cfg_ready=1 again; done_clr -> done=0.
- Down, auto-reload, PRESCALE=3 build: L=2, down=1.
  - Required: q=2,1,0,2,... each value held 3 cycles.
  - tc pulses every 9 cycles; busy stays 1.
- Pause/resume: L=9 up, pause high for 4 cycles at q=4 -> q stays 4, state=10.
  - After release, q continues 5..9; total period grows by 4 cycles.
- Abort and handshake: during RUN at q=3, cfg_valid=1 -> cfg_ready=0 (stalled).
  - Then abort -> state=00, q=0, no tc; stalled config is accepted the next cycle.
- Edge cases: L=0 one-shot -> DONE after 1 step with tc.
  - start and cfg accepted together -> run uses new L.
  - Async rst asserted mid-RUN -> all outputs return to reset values before the next clk edge.
